// File: rtl/conv_enc_213.sv
// Framed (2,1,3) rate-1/2 convolutional encoder with zero-tail termination.
// Information bits arrive over valid/ready; coded symbols leave through a held valid/ack register.
module conv_enc_213 #(
  parameter int         N  = 64,
  parameter int         M  = 3,
  parameter logic [3:0] G0 = 4'b1111,
  parameter logic [3:0] G1 = 4'b1101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ack,
  output logic       seq_ready,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [8:0] LAST_BIT  = 9'(N - 1);
  localparam logic [1:0] LAST_TAIL = 2'(M - 1);

  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

  // Tap window puts the current bit at G[3] and the oldest history bit at G[0].
  function automatic logic [1:0] encode_sym(input logic u, input logic [2:0] s);
    logic [3:0] w;
    w = {u, s[0], s[1], s[2]};
    return {parity4(G0 & w), parity4(G1 & w)};
  endfunction

  state_t     state_r;
  state_t     state_s;
  logic [2:0] shreg_r;
  logic [8:0] bit_cnt_r;
  logic [1:0] tail_cnt_r;
  logic [1:0] sym_out_r;
  logic       sym_valid_r;
  logic       seq_ready_r;
  logic       frame_done_r;
  logic       slot_s;
  logic       enc_load_s;
  logic       tail_load_s;
  logic       load_s;
  logic       u_s;
  logic       din_ready_s;
  logic       drain_done_s;

  // Next-state and per-cycle load decisions.
  always_comb begin
    state_s      = state_r;
    slot_s       = !sym_valid_r || sym_ack;
    enc_load_s   = 1'b0;
    tail_load_s  = 1'b0;
    u_s          = 1'b0;
    din_ready_s  = 1'b0;
    drain_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_ENCODE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        din_ready_s = slot_s;
        if (din_valid && slot_s) begin
          enc_load_s = 1'b1;
          u_s        = din;
          if (bit_cnt_r == LAST_BIT) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_ENCODE;
          end
        end else begin
          state_s = ST_ENCODE;
        end
      end
      ST_FLUSH: begin
        if (slot_s) begin
          tail_load_s = 1'b1;
          if (tail_cnt_r == LAST_TAIL) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (sym_valid_r && sym_ack) begin
          drain_done_s = 1'b1;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    load_s = enc_load_s || tail_load_s;
  end

  // State, trellis history, counters and the symbol register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      shreg_r    <= 3'b000;
      bit_cnt_r  <= 9'd0;
      tail_cnt_r <= 2'd0;
      sym_out_r  <= 2'b00;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        shreg_r   <= {shreg_r[1:0], u_s};
        sym_out_r <= encode_sym(u_s, shreg_r);
      end else if (drain_done_s) begin
        shreg_r <= 3'b000;
      end
      if (drain_done_s) begin
        bit_cnt_r  <= 9'd0;
        tail_cnt_r <= 2'd0;
      end else begin
        if (enc_load_s) begin
          bit_cnt_r <= bit_cnt_r + 9'd1;
        end
        if (tail_load_s) begin
          tail_cnt_r <= tail_cnt_r + 2'd1;
        end
      end
    end
  end

  // Handshake and frame status flags; a same-cycle ack and load keeps sym_valid high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sym_valid_r  <= 1'b0;
      seq_ready_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      if (load_s) begin
        sym_valid_r <= 1'b1;
      end else if (sym_ack) begin
        sym_valid_r <= 1'b0;
      end
      if (drain_done_s) begin
        seq_ready_r <= 1'b0;
      end else if (load_s) begin
        seq_ready_r <= 1'b1;
      end
      frame_done_r <= drain_done_s;
    end
  end

  assign din_ready  = din_ready_s;
  assign sym_out    = sym_out_r;
  assign sym_valid  = sym_valid_r;
  assign seq_ready  = seq_ready_r;
  assign frame_done = frame_done_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_conv_enc_213.sv
// Randomized self-checking bench for conv_enc_213 (N=4 and N=64 instances).
// A transaction-level model convolves consumed bits with the generator taps.
module tb_conv_enc_213;

  logic       clock = 1'b0;
  logic       reset, start, din, din_valid, sym_ack;
  logic       sel;
  logic       start4, start64;
  logic       dr4, sv4, sr4, fd4, bz4;
  logic       dr64, sv64, sr64, fd64, bz64;
  logic [1:0] so4, so64;
  logic       din_ready, sym_valid, seq_ready, frame_done, busy;
  logic [1:0] sym_out;

  always #5 clock = ~clock;

  assign start4     = start && !sel;
  assign start64    = start && sel;
  assign din_ready  = sel ? dr64 : dr4;
  assign sym_valid  = sel ? sv64 : sv4;
  assign seq_ready  = sel ? sr64 : sr4;
  assign frame_done = sel ? fd64 : fd4;
  assign busy       = sel ? bz64 : bz4;
  assign sym_out    = sel ? so64 : so4;

  conv_enc_213 #(.N(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .din(din), .din_valid(din_valid),
    .din_ready(dr4), .sym_out(so4), .sym_valid(sv4), .sym_ack(sym_ack),
    .seq_ready(sr4), .frame_done(fd4), .busy(bz4));

  conv_enc_213 #(.N(64)) dut64 (
    .clock(clock), .reset(reset), .start(start64), .din(din), .din_valid(din_valid),
    .din_ready(dr64), .sym_out(so64), .sym_valid(sv64), .sym_ack(sym_ack),
    .seq_ready(sr64), .frame_done(fd64), .busy(bz64));

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_n;
  bit         m_active, m_pending, m_done;
  int         m_loaded, m_acked;
  logic [1:0] m_sym;
  logic       bits [0:511];
  int         fd_cnt, seq_cnt;
  bit         kv_en;
  logic       kv_bit [0:3];
  logic [1:0] kv_sym [0:6];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol k = generator taps applied to bits k..k-3 (zero before the frame and in the tail).
  function automatic logic [1:0] ref_sym(input int k);
    logic       c0, c1, b;
    logic [3:0] g0, g1;
    g0 = 4'b1111;
    g1 = 4'b1101;
    c0 = 1'b0;
    c1 = 1'b0;
    for (int d = 0; d < 4; d++) begin
      b = (k - d >= 0 && k - d < m_n) ? bits[k - d] : 1'b0;
      if (g0[3 - d]) c0 = c0 ^ b;
      if (g1[3 - d]) c1 = c1 ^ b;
    end
    return {c0, c1};
  endfunction

  task automatic model_clear();
    m_active  = 1'b0;
    m_pending = 1'b0;
    m_done    = 1'b0;
    m_loaded  = 0;
    m_acked   = 0;
    m_sym     = 2'b00;
  endtask

  task automatic cycle(input bit rst, input bit st, input bit dv, input bit d, input bit ack);
    bit slot, was, load, acked, fin;
    @(negedge clock);
    reset = rst; start = st; din_valid = dv; din = d; sym_ack = ack;
    #1;
    slot = !m_pending || ack;
    check_val("busy", 32'(busy), 32'(m_active));
    check_val("sym_valid", 32'(sym_valid), 32'(m_pending));
    check_val("sym_out", 32'(sym_out), 32'(m_sym));
    check_val("seq_ready", 32'(seq_ready), 32'(m_active && m_loaded > 0));
    check_val("frame_done", 32'(frame_done), 32'(m_done));
    check_val("din_ready", 32'(din_ready), 32'(m_active && m_loaded < m_n && slot));
    if (frame_done) fd_cnt++;
    if (seq_ready) seq_cnt++;
    if (rst) begin
      model_clear();
    end else begin
      was   = m_active;
      load  = 1'b0;
      acked = m_pending && ack;
      if (acked) begin
        if (kv_en && m_acked < 7) check_val("kv_sym", 32'(sym_out), 32'(kv_sym[m_acked]));
        m_acked++;
      end
      if (m_active) begin
        if (m_loaded < m_n) begin
          if (dv && slot) begin
            bits[m_loaded] = d;
            load = 1'b1;
          end
        end else if (m_loaded < m_n + 3) begin
          load = slot;
        end
      end
      fin = m_active && (m_loaded == m_n + 3) && acked;
      if (load) begin
        m_sym     = ref_sym(m_loaded);
        m_loaded++;
        m_pending = 1'b1;
      end else if (acked) begin
        m_pending = 1'b0;
      end
      m_done = fin;
      if (fin) m_active = 1'b0;
      if (!was && st) begin
        m_active = 1'b1;
        m_loaded = 0;
        m_acked  = 0;
      end
    end
  endtask

  // mode: 0 random bits, 1 known vector, 2 all zeros; abort_at >= 0 stops after that many acks.
  task automatic run_frame(input int mode, input int gap_pct, input int ack_pct,
                           input int bp_cycles, input bit stray, input int abort_at);
    int budget, bp;
    bit dv, d, ack, st;
    budget = 0;
    bp     = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(1, 0)), 1'b1);
    while (m_active && budget < 3000) begin
      if (abort_at >= 0 && m_acked >= abort_at) break;
      dv = int'($urandom_range(99, 0)) >= gap_pct;
      case (mode)
        1:       d = (m_loaded < 4) ? kv_bit[m_loaded] : 1'b0;
        2:       d = 1'b0;
        default: d = 1'($urandom_range(1, 0));
      endcase
      ack = int'($urandom_range(99, 0)) < ack_pct;
      if (m_loaded >= 1 && bp < bp_cycles) begin
        ack = 1'b0;
        bp++;
      end
      st = stray && ($urandom_range(3, 0) == 0);
      cycle(1'b0, st, dv, d, ack);
      budget++;
    end
    if (abort_at < 0) begin
      check_val("frame_end", 32'(m_active), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; sym_ack = 1'b0;
    sel = 1'b0; m_n = 4; kv_en = 1'b0; fd_cnt = 0; seq_cnt = 0;
    model_clear();
    kv_bit[0] = 1'b1; kv_bit[1] = 1'b0; kv_bit[2] = 1'b1; kv_bit[3] = 1'b1;
    kv_sym[0] = 2'b11; kv_sym[1] = 2'b11; kv_sym[2] = 2'b01; kv_sym[3] = 2'b11;
    kv_sym[4] = 2'b01; kv_sym[5] = 2'b01; kv_sym[6] = 2'b11;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Known vector with ack held high
    kv_en = 1'b1; fd_cnt = 0;
    run_frame(1, 0, 100, 0, 1'b0, -1);
    check_val("kv_done_pulses", 32'(fd_cnt), 32'd1);
    check_val("kv_sym_count", 32'(m_acked), 32'd7);

    // Backpressure after the first symbol, same sequence expected
    fd_cnt = 0;
    run_frame(1, 0, 100, 5, 1'b0, -1);
    check_val("bp_done_pulses", 32'(fd_cnt), 32'd1);
    check_val("bp_sym_count", 32'(m_acked), 32'd7);
    kv_en = 1'b0;

    // Random bits, gapped input, random ack, stray starts
    for (int f = 0; f < 6; f++) begin
      fd_cnt = 0;
      run_frame(0, 40, 70, 0, 1'b1, -1);
      check_val("rnd_done_pulses", 32'(fd_cnt), 32'd1);
    end

    // Reset after two symbols, then the known frame again
    kv_en = 1'b1;
    run_frame(1, 0, 100, 0, 1'b0, 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fd_cnt = 0;
    run_frame(1, 0, 100, 0, 1'b0, -1);
    check_val("rst_done_pulses", 32'(fd_cnt), 32'd1);
    check_val("rst_sym_count", 32'(m_acked), 32'd7);
    kv_en = 1'b0;

    // Switch to the N=64 instance
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1; m_n = 64;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fd_cnt = 0; seq_cnt = 0;
    run_frame(2, 0, 100, 0, 1'b0, -1);
    check_val("zero_seq_ready_cycles", 32'(seq_cnt), 32'd67);
    check_val("zero_done_pulses", 32'(fd_cnt), 32'd1);
    check_val("zero_sym_count", 32'(m_acked), 32'd67);

    fd_cnt = 0;
    run_frame(0, 30, 60, 3, 1'b1, -1);
    check_val("rnd64_done_pulses", 32'(fd_cnt), 32'd1);
    check_val("rnd64_sym_count", 32'(m_acked), 32'd67);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_enc_213.md
# conv_enc_213

Framed convolutional encoder for the (2,1,3) code: rate 1/2, memory m=3, 8 trellis states. It is the transmit-side counterpart of the (2,1,3) Viterbi decoder. It accepts N information bits per frame over a valid/ready handshake and emits one 2-bit coded symbol per bit through a held valid/ack output register. It then appends m=3 zero tail bits so the trellis terminates in state 0, and raises `seq_ready` toward the decoder side for the duration of the frame.

## Interface
- `N`, 64: information bits per frame; legal range 1..508.
- `M`, 3: encoder memory (tail length); fixed at 3.
- `G0`, 4'b1111: generator for `sym_out[1]` (octal 17).
- `G1`, 4'b1101: generator for `sym_out[0]` (octal 15).
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle frame start request; honoured only in IDLE.
- `din`  in  1  information bit.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  encoder accepts `din` this cycle.
- `sym_out`  out  2  coded symbol `{c0, c1}`.
- `sym_valid`  out  1  `sym_out` holds an unconsumed symbol.
- `sym_ack`  in  1  consumer takes `sym_out` this cycle.
- `seq_ready`  out  1  frame in progress, symbols are flowing.
- `frame_done`  out  1  one-cycle pulse after the last tail symbol is acked.
- `busy`  out  1  state is not IDLE.

## Operation
- State register `s[2:0]`: `s[0]` holds the most recent past bit, `s[2]` the oldest.
- Tap window is `{u, s[0], s[1], s[2]}`, aligned to G[3:0].
- `c0 = ^(G0 & window)` and `c1 = ^(G1 & window)`.
- With the default generators: `c0 = u^s0^s1^s2`, `c1 = u^s0^s2`.
- Update on every encoded bit: `s <= {s[1], s[0], u}`.
- Output slot free: `slot = !sym_valid | sym_ack`.
- States:
  - IDLE: `s` = 0 and `bit_cnt` = 0. On `start`, go to ENCODE.
  - ENCODE: `din_ready = slot`. On `din_valid & din_ready`, encode `u = din`, load `sym_out`, set `sym_valid`, and increment `bit_cnt` (9 bits). When the N-th bit is accepted, go to FLUSH.
  - FLUSH: `din_ready` = 0. Each cycle with `slot` = 1, encode `u = 0`, load the symbol, and increment `tail_cnt` (2 bits). After the 3rd tail symbol is loaded, go to DRAIN.
  - DRAIN: wait for `sym_valid & sym_ack`. Then go to IDLE, set `frame_done` for one cycle, clear `seq_ready`, and clear `s`.
- `sym_valid` clears on `sym_ack` unless a new symbol is loaded in the same cycle. A simultaneous ack and load keeps `sym_valid` at 1 with the new data.
- `sym_out` is stable while `sym_valid & !sym_ack`.
- `seq_ready` sets on the first symbol load of the frame and stays high until the DRAIN-to-IDLE transition.
- `start` outside IDLE is ignored. `sym_ack` while `sym_valid` = 0 is ignored.
- `din_valid` outside ENCODE is ignored; no bit is consumed.
- Exactly N+3 symbols are produced per frame; after the tail, `s` = 000.
- Reset (any state, mid-frame included) forces IDLE and clears `s`, the counters and all outputs. No partial frame resumes.

## Timing
- Reset values: `din_ready`=0, `sym_out`=00, `sym_valid`=0, `seq_ready`=0, `frame_done`=0, `busy`=0.
- `start` at cycle t puts the block in ENCODE at t+1; `din_ready` can be 1 at t+1.
- Latency: a bit accepted at edge t gives `sym_valid`=1 with its symbol after edge t (visible in cycle t+1).
- Throughput is 1 symbol/cycle with `sym_ack` held at 1; the full frame takes N+3 load cycles plus one DRAIN cycle.
- With `sym_ack`=0, at most one symbol is buffered and `din_ready` drops the cycle after a load.
- Last ack at edge t gives `frame_done`=1, `seq_ready`=0, `busy`=0 in cycle t+1. `start` is accepted again in cycle t+1.

## Test plan
- Known vector: N=4, din 1,0,1,1, `sym_ack` tied to 1 → `sym_out` 11,11,01,11, then tail 01,01,11. `frame_done` pulses once; final `s`=000.
- All-zero frame: N=64, all zeros → 67 symbols, all 00. `seq_ready` is high for 67 cycles; `frame_done` pulses once.
- Backpressure: hold `sym_ack`=0 for 5 cycles after the first symbol → `sym_out`/`sym_valid` stay stable, `din_ready`=0, and no bit is lost. Releasing the ack resumes the sequence unchanged.
- Gapped input: toggle `din_valid` randomly → symbol sequence is identical to the gap-free run. `din_ready` is never 1 in FLUSH or DRAIN.
- Reset mid-frame: reset after the 2nd symbol of N=4 → next cycle all outputs are at reset values. A new frame with 1,0,1,1 reproduces 11,11,01,11,01,01,11.
- Ignored controls: `start` pulses in ENCODE and FLUSH, and `din_valid`=1 in IDLE → no state change, no symbol, no count change.
